// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order commit of out-of-order results, operand tag query with
// CDB bypass, and full flush on a mispredicted jump.
module reorder_buffer #(
    parameter int unsigned ROB_SIZE = 8,
    parameter int unsigned ROB_ID_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                ena_from_dispatcher,
    input  logic [4:0]          rd_from_dispatcher,
    input  logic                is_jump_from_dispatcher,
    input  logic                is_store_from_dispatcher,
    input  logic                predicted_jump_from_dispatcher,
    input  logic [31:0]         pc_from_dispatcher,
    output logic [ROB_ID_W-1:0] rob_id_to_dispatcher,
    output logic                full_to_if,
    input  logic [ROB_ID_W-1:0] Q1_from_dispatcher,
    input  logic [ROB_ID_W-1:0] Q2_from_dispatcher,
    output logic                Q1_ready_to_dispatcher,
    output logic                Q2_ready_to_dispatcher,
    output logic [31:0]         data1_to_dispatcher,
    output logic [31:0]         data2_to_dispatcher,
    input  logic                valid_from_rs_cdb,
    input  logic [ROB_ID_W-1:0] rob_id_from_rs_cdb,
    input  logic [31:0]         result_from_rs_cdb,
    input  logic                real_jump_from_rs_cdb,
    input  logic [31:0]         target_pc_from_rs_cdb,
    input  logic                valid_from_ls_cdb,
    input  logic [ROB_ID_W-1:0] rob_id_from_ls_cdb,
    input  logic [31:0]         result_from_ls_cdb,
    output logic                commit_ena_to_reg,
    output logic [4:0]          commit_rd_to_reg,
    output logic [ROB_ID_W-1:0] commit_rob_id_to_reg,
    output logic [31:0]         commit_data_to_reg,
    output logic                commit_store_to_lsb,
    output logic [ROB_ID_W-1:0] commit_rob_id_to_lsb,
    output logic                rollback_flag,
    output logic [31:0]         target_pc_to_if,
    output logic                bp_update_ena,
    output logic [31:0]         bp_pc,
    output logic                bp_taken
);

    localparam int unsigned IDX_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
    localparam int unsigned CNT_W = $clog2(ROB_SIZE + 1);

    logic [IDX_W-1:0]    r_head, r_tail;
    logic [CNT_W-1:0]    r_count;
    logic [ROB_SIZE-1:0] r_busy, r_ready, r_is_jump, r_is_store, r_pred, r_real_jump;
    logic [4:0]          r_rd     [ROB_SIZE];
    logic [31:0]         r_pc     [ROB_SIZE];
    logic [31:0]         r_result [ROB_SIZE];
    logic [31:0]         r_target [ROB_SIZE];

    logic [ROB_SIZE-1:0] w_rs_hit, w_ls_hit;
    logic                w_alloc, w_commit, w_mispredict;
    logic [ROB_ID_W-1:0] w_head_id;
    logic [ROB_ID_W-1:0] w_q_tag [2];
    logic [1:0]          w_q_ready;
    logic [1:0][31:0]    w_q_data;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(ROB_SIZE - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign full_to_if           = (r_count == CNT_W'(ROB_SIZE));
    assign rob_id_to_dispatcher = ROB_ID_W'(r_tail) + ROB_ID_W'(1);
    assign w_head_id            = ROB_ID_W'(r_head) + ROB_ID_W'(1);
    assign w_alloc              = ena_from_dispatcher && !full_to_if;
    assign w_commit             = r_busy[r_head] && r_ready[r_head];
    assign w_mispredict         = w_commit && r_is_jump[r_head] &&
                                  (r_real_jump[r_head] != r_pred[r_head]);

    // Stores only complete through the load/store CDB.
    always_comb begin
        w_rs_hit = '0;
        w_ls_hit = '0;
        for (int i = 0; i < int'(ROB_SIZE); i++) begin
            w_rs_hit[i] = valid_from_rs_cdb && (rob_id_from_rs_cdb == ROB_ID_W'(i + 1)) &&
                          r_busy[i] && !r_is_store[i];
            w_ls_hit[i] = valid_from_ls_cdb && (rob_id_from_ls_cdb == ROB_ID_W'(i + 1)) &&
                          r_busy[i];
        end
    end

    assign w_q_tag[0] = Q1_from_dispatcher;
    assign w_q_tag[1] = Q2_from_dispatcher;

    always_comb begin
        w_q_ready = '0;
        w_q_data  = '0;
        for (int q = 0; q < 2; q++) begin
            if (w_q_tag[q] == '0) begin
                w_q_ready[q] = 1'b1;
            end else begin
                for (int i = 0; i < int'(ROB_SIZE); i++) begin
                    if ((w_q_tag[q] == ROB_ID_W'(i + 1)) && r_busy[i] && r_ready[i]) begin
                        w_q_ready[q] = 1'b1;
                        w_q_data[q]  = r_result[i];
                    end
                end
                if (!w_q_ready[q]) begin
                    if (valid_from_rs_cdb && (rob_id_from_rs_cdb == w_q_tag[q])) begin
                        w_q_ready[q] = 1'b1;
                        w_q_data[q]  = result_from_rs_cdb;
                    end else if (valid_from_ls_cdb && (rob_id_from_ls_cdb == w_q_tag[q])) begin
                        w_q_ready[q] = 1'b1;
                        w_q_data[q]  = result_from_ls_cdb;
                    end
                end
            end
        end
    end

    assign Q1_ready_to_dispatcher = w_q_ready[0];
    assign Q2_ready_to_dispatcher = w_q_ready[1];
    assign data1_to_dispatcher    = w_q_data[0];
    assign data2_to_dispatcher    = w_q_data[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_busy      <= '0;
            r_ready     <= '0;
            r_is_jump   <= '0;
            r_is_store  <= '0;
            r_pred      <= '0;
            r_real_jump <= '0;
            for (int i = 0; i < int'(ROB_SIZE); i++) begin
                r_rd[i]     <= '0;
                r_pc[i]     <= '0;
                r_result[i] <= '0;
                r_target[i] <= '0;
            end
            commit_ena_to_reg    <= 1'b0;
            commit_rd_to_reg     <= '0;
            commit_rob_id_to_reg <= '0;
            commit_data_to_reg   <= '0;
            commit_store_to_lsb  <= 1'b0;
            commit_rob_id_to_lsb <= '0;
            rollback_flag        <= 1'b0;
            target_pc_to_if      <= '0;
            bp_update_ena        <= 1'b0;
            bp_pc                <= '0;
            bp_taken             <= 1'b0;
        end else begin
            // All outputs are single-cycle pulses; they fall back to 0 unless re-fired.
            commit_ena_to_reg    <= 1'b0;
            commit_rd_to_reg     <= '0;
            commit_rob_id_to_reg <= '0;
            commit_data_to_reg   <= '0;
            commit_store_to_lsb  <= 1'b0;
            commit_rob_id_to_lsb <= '0;
            rollback_flag        <= 1'b0;
            target_pc_to_if      <= '0;
            bp_update_ena        <= 1'b0;
            bp_pc                <= '0;
            bp_taken             <= 1'b0;
            if (rdy) begin
                if (w_commit) begin
                    if (r_is_store[r_head]) begin
                        commit_store_to_lsb  <= 1'b1;
                        commit_rob_id_to_lsb <= w_head_id;
                    end else if (r_rd[r_head] != 5'd0) begin
                        commit_ena_to_reg    <= 1'b1;
                        commit_rd_to_reg     <= r_rd[r_head];
                        commit_rob_id_to_reg <= w_head_id;
                        commit_data_to_reg   <= r_result[r_head];
                    end
                    if (r_is_jump[r_head]) begin
                        bp_update_ena <= 1'b1;
                        bp_pc         <= r_pc[r_head];
                        bp_taken      <= r_real_jump[r_head];
                    end
                end
                if (w_mispredict) begin
                    rollback_flag   <= 1'b1;
                    target_pc_to_if <= r_real_jump[r_head] ? r_target[r_head]
                                                           : r_pc[r_head] + 32'd4;
                    r_busy  <= '0;
                    r_ready <= '0;
                    r_head  <= '0;
                    r_tail  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_alloc) begin
                        r_busy[r_tail]      <= 1'b1;
                        r_ready[r_tail]     <= 1'b0;
                        r_rd[r_tail]        <= rd_from_dispatcher;
                        r_is_jump[r_tail]   <= is_jump_from_dispatcher;
                        r_is_store[r_tail]  <= is_store_from_dispatcher;
                        r_pred[r_tail]      <= predicted_jump_from_dispatcher;
                        r_pc[r_tail]        <= pc_from_dispatcher;
                        r_result[r_tail]    <= '0;
                        r_real_jump[r_tail] <= 1'b0;
                        r_target[r_tail]    <= '0;
                        r_tail              <= next_idx(r_tail);
                    end
                    for (int i = 0; i < int'(ROB_SIZE); i++) begin
                        if (w_rs_hit[i]) begin
                            r_ready[i]     <= 1'b1;
                            r_result[i]    <= result_from_rs_cdb;
                            r_real_jump[i] <= real_jump_from_rs_cdb;
                            r_target[i]    <= target_pc_from_rs_cdb;
                        end
                        if (w_ls_hit[i]) begin
                            r_ready[i]  <= 1'b1;
                            r_result[i] <= result_from_ls_cdb;
                        end
                    end
                    if (w_commit) begin
                        r_busy[r_head]  <= 1'b0;
                        r_ready[r_head] <= 1'b0;
                        r_head          <= next_idx(r_head);
                    end
                    case ({w_alloc, w_commit})
                        2'b10:   r_count <= r_count + CNT_W'(1);
                        2'b01:   r_count <= r_count - CNT_W'(1);
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    end

endmodule
